// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: expands LM/SM register lists into one load/store micro-op per cycle.
// Define LMSM_ZERO_TRAP_EN to flag zero-list LM/SM on zero_list_err.
module lm_sm_sequencer #(
   parameter logic [3:0] OPC_LM = 4'b0110,
   parameter logic [3:0] OPC_SM = 4'b0111,
   parameter int         MASK_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr_in,
   input  logic        valid_in,
   input  logic        stall_id,
   input  logic        flush,
   output logic        M_inst,
   output logic        busy,
   output logic        uop_valid,
   output logic        uop_is_load,
   output logic [2:0]  uop_ra,
   output logic [2:0]  uop_reg,
   output logic [2:0]  uop_offset,
   output logic        uop_last,
   output logic        zero_list_err
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t            state, state_n;
   logic [MASK_W-1:0] mask, mask_r, mask_n;
   logic [2:0]        ra_r, ra_n, cnt, cnt_n, low;
   logic              ld_r, ld_n, is_multi, accept, last, run, unused_b8;
   assign unused_b8 = instr_in[8];
   assign mask      = instr_in[MASK_W-1:0];
   assign is_multi  = (instr_in[15:12] == OPC_LM) || (instr_in[15:12] == OPC_SM);
   assign run       = (state == RUN);
   assign accept    = !run && valid_in && is_multi && |mask && !stall_id && !flush;
   // exactly one bit left: clearing the lowest set bit empties the list
   assign last      = |mask_r && ~|(mask_r & (mask_r - MASK_W'(1)));
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         mask_r <= '0;
         ra_r   <= '0;
         ld_r   <= 1'b0;
         cnt    <= '0;
      end else begin
         state  <= state_n;
         mask_r <= mask_n;
         ra_r   <= ra_n;
         ld_r   <= ld_n;
         cnt    <= cnt_n;
      end
   end
   always_comb begin
      state_n = state;
      mask_n  = mask_r;
      ra_n    = ra_r;
      ld_n    = ld_r;
      cnt_n   = cnt;
      if (accept) begin
         state_n = RUN;
         mask_n  = mask;
         ra_n    = instr_in[11:9];
         ld_n    = (instr_in[15:12] == OPC_LM);
         cnt_n   = '0;
      end else if (run && flush) begin
         state_n = IDLE;
         mask_n  = '0;
         cnt_n   = '0;
      end else if (run && !stall_id) begin
         state_n = last ? IDLE : RUN;
         mask_n  = mask_r & (mask_r - MASK_W'(1));
         cnt_n   = last ? 3'd0 : cnt + 3'd1;
      end
   end
   always_comb begin
      low = '0;
      for (int i = MASK_W - 1; i >= 0; i--)
         if (mask_r[i]) low = 3'(i);
      busy        = run;
      uop_valid   = run && !flush;
      uop_last    = run && !flush && last;
      uop_is_load = run && ld_r;
      uop_ra      = run ? ra_r : 3'd0;
      uop_reg     = run ? low : 3'd0;
      uop_offset  = run ? cnt : 3'd0;
      M_inst      = run ? (!flush && !(last && !stall_id)) : (valid_in && is_multi && |mask && !flush);
   end
`ifdef LMSM_ZERO_TRAP_EN
   always_ff @(posedge clk)
      zero_list_err <= !reset && !run && valid_in && is_multi && ~|mask && !stall_id && !flush;
`else
   assign zero_list_err = 1'b0;
`endif
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: directed checks of LM/SM expansion, stalls, flush, zero list and reset.
module tb_lm_sm_sequencer;
   logic        clk = 0, reset = 1, valid_in = 0, stall_id = 0, flush = 0;
   logic [15:0] instr_in = '0;
   logic        M_inst, busy, uop_valid, uop_is_load, uop_last, zero_list_err;
   logic [2:0]  uop_ra, uop_reg, uop_offset;
   int          n_chk = 0, n_fail = 0, nv = 0;
`ifdef LMSM_ZERO_TRAP_EN
   localparam logic ZERR = 1'b1;
`else
   localparam logic ZERR = 1'b0;
`endif
   lm_sm_sequencer dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .valid_in(valid_in),
      .stall_id(stall_id), .flush(flush), .M_inst(M_inst), .busy(busy),
      .uop_valid(uop_valid), .uop_is_load(uop_is_load), .uop_ra(uop_ra),
      .uop_reg(uop_reg), .uop_offset(uop_offset), .uop_last(uop_last),
      .zero_list_err(zero_list_err)
   );
   always #5 clk = ~clk;
   task automatic go();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic idle(input string tag, input logic m);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " valid"}, uop_valid, 0);
      chk({tag, " last"}, uop_last, 0);
      chk({tag, " M_inst"}, M_inst, m);
   endtask
   task automatic uop(input string tag, input int r, input int off, input int ld, input int ra, input int lst, input int m);
      nv += uop_valid;
      chk({tag, " valid"}, uop_valid, 1);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " reg"}, uop_reg, r);
      chk({tag, " off"}, uop_offset, off);
      chk({tag, " load"}, uop_is_load, ld);
      chk({tag, " ra"}, uop_ra, ra);
      chk({tag, " last"}, uop_last, lst);
      chk({tag, " M_inst"}, M_inst, m);
   endtask
   initial begin
      int regs [4] = '{0, 2, 5, 7};
      go(); go();
      reset = 0;
      go();
      idle("rst", 0);
      chk("rst reg", uop_reg, 0);
      chk("rst ra", uop_ra, 0);
      chk("rst zerr", zero_list_err, 0);
      // LM R2, list A5
      instr_in = 16'h64A5; valid_in = 1; #1;
      idle("lm dec", 1);
      for (int i = 0; i < 4; i++) begin
         go();
         uop($sformatf("lm u%0d", i), regs[i], i, 1, 2, i == 3, i != 3);
      end
      valid_in = 0;
      go();
      idle("lm end", 0);
      // SM R1, single register R3
      instr_in = 16'h7208; valid_in = 1; #1;
      idle("sm dec", 1);
      go();
      uop("sm u0", 3, 0, 0, 1, 1, 0);
      valid_in = 0;
      go();
      idle("sm end", 0);
      // stall during R2 for two cycles
      nv = 0;
      instr_in = 16'h64A5; valid_in = 1;
      go(); uop("st r0", 0, 0, 1, 2, 0, 1);
      go(); uop("st r2a", 2, 1, 1, 2, 0, 1);
      stall_id = 1;
      go(); uop("st r2b", 2, 1, 1, 2, 0, 1);
      go(); uop("st r2c", 2, 1, 1, 2, 0, 1);
      stall_id = 0;
      go(); uop("st r5", 5, 2, 1, 2, 0, 1);
      go(); uop("st r7", 7, 3, 1, 2, 1, 0);
      valid_in = 0;
      go();
      idle("st end", 0);
      chk("st count", nv, 6);
      // flush on third micro-op of full list
      instr_in = 16'h60FF; valid_in = 1;
      go(); uop("fl r0", 0, 0, 1, 0, 0, 1);
      go(); uop("fl r1", 1, 1, 1, 0, 0, 1);
      go(); uop("fl r2", 2, 2, 1, 0, 0, 1);
      flush = 1; valid_in = 0; #1;
      chk("fl valid", uop_valid, 0);
      chk("fl last", uop_last, 0);
      chk("fl M_inst", M_inst, 0);
      chk("fl busy", busy, 1);
      go();
      flush = 0; #1;
      idle("fl end", 0);
      instr_in = 16'h7208; valid_in = 1;
      go(); uop("fl sm", 3, 0, 0, 1, 1, 0);
      valid_in = 0;
      go();
      idle("fl sm end", 0);
      // flush with a new LM in IDLE: no accept
      instr_in = 16'h64A5; valid_in = 1; flush = 1; #1;
      idle("fi dec", 0);
      go();
      flush = 0; valid_in = 0; #1;
      idle("fi end", 0);
      // zero register list
      instr_in = 16'h6000; valid_in = 1; #1;
      idle("z dec", 0);
      go();
      idle("z nop", 0);
      chk("z err", zero_list_err, ZERR);
      valid_in = 0;
      go();
      chk("z err pulse", zero_list_err, 0);
      // reset mid-run, then restart
      instr_in = 16'h64A5; valid_in = 1;
      go(); uop("rs r0", 0, 0, 1, 2, 0, 1);
      go(); uop("rs r2", 2, 1, 1, 2, 0, 1);
      reset = 1; valid_in = 0;
      go();
      idle("rs abort", 0);
      chk("rs reg", uop_reg, 0);
      chk("rs off", uop_offset, 0);
      chk("rs ra", uop_ra, 0);
      chk("rs load", uop_is_load, 0);
      reset = 0; valid_in = 1;
      go(); uop("rs re0", 0, 0, 1, 2, 0, 1);
      go(); uop("rs re2", 2, 1, 1, 2, 0, 1);
      go(); uop("rs re5", 5, 2, 1, 2, 0, 1);
      go(); uop("rs re7", 7, 3, 1, 2, 1, 0);
      valid_in = 0;
      go();
      idle("rs end", 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Decode-stage micro-sequencer for the multiple-register instructions LM and SM.
- Takes a valid LM/SM word from the IF/ID register and expands it into one load/store micro-op per selected register, one per cycle.
- Drives M_inst into the hazard unit, so IF is frozen and the new instruction is not lost while the expansion runs.
- Consumes the hazard unit's ID validity and ID stall bit (stall[3]) to hold or abort the expansion.

Parameters:
- OPC_LM, 4'b0110, opcode of LM (instr[15:12]).
- OPC_SM, 4'b0111, opcode of SM.
- MASK_W, 8, register-list width; fixed at 8 (R0..R7). Any other value is unsupported.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active high; sampled on rising clk.
- instr_in  in  16  instruction word from IF/ID register.
- valid_in  in  1  Validity_IF_ID from hazard unit.
- stall_id  in  1  stall[3] from hazard unit; hold current micro-op.
- flush  in  1  high when the hazard unit invalidates the ID stage (R7 write, BEQ taken, JLR).
- M_inst  out  1  request to the hazard unit to freeze fetch.
- busy  out  1  state is RUN.
- uop_valid  out  1  micro-op valid this cycle.
- uop_is_load  out  1  1 = LM micro-op (load), 0 = SM micro-op (store).
- uop_ra  out  3  base register field (instr[11:9]) of the latched instruction.
- uop_reg  out  3  data register index for this micro-op.
- uop_offset  out  3  address offset; address = RA + uop_offset.
- uop_last  out  1  final micro-op of the instruction.
- zero_list_err  out  1  see Optional Feature.

Behaviour:
- Decode (combinational on instr_in):
  - is_multi = (instr_in[15:12]==OPC_LM || instr_in[15:12]==OPC_SM).
  - mask = instr_in[7:0]; bit i selects Ri.
  - instr_in[8] is ignored.
- Two states: IDLE and RUN. Registers: mask_r[7:0], ra_r[2:0], ld_r, cnt[2:0].
- Reset (synchronous): state=IDLE, mask_r=0, ra_r=0, ld_r=0, cnt=0. All outputs read 0 in the cycle after reset is sampled.
- IDLE:
  - uop_valid=0 and busy=0.
  - M_inst = valid_in & is_multi & (mask!=0) & !flush. IF freezes in the same cycle the LM/SM is in ID.
  - Accept when valid_in & is_multi & mask!=0 & !stall_id & !flush. On accept: mask_r<=mask, ra_r<=instr_in[11:9], ld_r<=(opcode==OPC_LM), cnt<=0, state<=RUN.
  - A non-multi word, or a zero-mask multi word, is ignored: no micro-op, state stays IDLE.
- RUN:
  - uop_valid=1, busy=1.
  - uop_reg = index of the lowest set bit of mask_r (R0 first).
  - uop_offset=cnt, uop_ra=ra_r, uop_is_load=ld_r.
  - uop_last = (mask_r has exactly one bit set).
  - M_inst = !(uop_last & !stall_id), so fetch resumes on the cycle after the last micro-op advances.
  - Advance when !stall_id: clear the lowest set bit of mask_r and increment cnt. If uop_last, state<=IDLE and cnt<=0.
  - When stall_id=1, all registers hold and all outputs stay stable.
- Latency: first micro-op is presented 1 cycle after accept. N set bits give N consecutive micro-op cycles with no stalls, and 1+N cycles from accept to IDLE. Offsets are dense: 0,1,..,N-1. cnt never wraps, since N ≤ 8.
- Flush in RUN:
  - Same cycle: uop_valid, uop_last and M_inst are forced to 0.
  - Next cycle: state=IDLE, mask_r=0, cnt=0.
  - Flush has priority over stall_id and over accept.
- Flush and a new LM/SM in IDLE in the same cycle: no accept.
- Reset mid-RUN: abort as for flush, at the next edge. Reset has priority over everything.

Optional Feature:
- Macro: LMSM_ZERO_TRAP_EN.
- Defined: in IDLE, when valid_in & is_multi & mask==0 & !stall_id & !flush, zero_list_err pulses high for exactly 1 cycle (registered, cycle after the condition). The instruction is still consumed as a NOP with no micro-op.
- Not defined: zero_list_err is tied to 0 and the zero-list LM/SM is a silent NOP.

Test Plan:
- LM, instr_in=16'h64A5 (RA=R2, mask 8'hA5), valid_in=1, no stalls:
  - uop_reg sequence 0,2,5,7 with offsets 0,1,2,3 and uop_is_load=1, uop_ra=2.
  - uop_last only on R7.
  - M_inst high from decode cycle through the R5 cycle, low on the R7 cycle.
- SM, instr_in=16'h7208 (RA=R1, mask 8'h08): exactly one micro-op with uop_reg=3, offset 0, uop_is_load=0, uop_last=1, M_inst=0 in that cycle; busy=0 on the next cycle.
- LM 16'h64A5 with stall_id=1 for 2 cycles during the R2 micro-op: R2/offset 1 is held for 3 cycles, then R5/offset 2 follows. Total micro-op cycles = 6.
- LM 16'h60FF (all 8 bits set) with flush=1 on the 3rd micro-op: uop_valid=0 in the flush cycle and busy=0 on the next cycle. A following SM 16'h7208 is accepted normally.
- LM 16'h6000 (zero mask): no uop_valid and M_inst=0. zero_list_err=1 for one cycle only when LMSM_ZERO_TRAP_EN is defined, otherwise 0.
- reset=1 asserted mid-RUN of 16'h64A5: on the next edge all outputs are 0 and state is IDLE. After reset deasserts, re-issue of 16'h64A5 restarts at R0, offset 0.
